// File: rtl/apb_reg_slave.sv
`default_nettype none
// ============================================================================
//  Module   : apb_reg_slave
//  Purpose  : APB3 completer front-end for the peripheral register bank.
//             Turns an APB setup/access pair into a single-cycle write
//             strobe towards the bank and returns the bank's current
//             register contents on prdata. Zero wait states by default.
//
//  Ports    : clk, resetn           - clock / asynchronous active-low reset
//             psel, penable, pwrite - APB control
//             paddr, pwdata         - APB byte address / write data
//             prdata, pready,
//             pslverr               - APB completion (all registered)
//             reg_rdata_flat        - bank contents, reg i at [i*W +: W]
//             reg_apb_wen,
//             reg_apb_addr,
//             reg_apb_wdata         - one-cycle write strobe to the bank
//
//  Options  : APB_REG_WAIT_EN - when defined, every transfer carries one
//             wait state (3-cycle transfer); prdata is re-sampled in the
//             wait cycle and a psel drop in the wait cycle aborts without
//             a write strobe.
//
//  Revision : 1.0 - initial release
// ============================================================================
module apb_reg_slave #(
    parameter int APB_DATA_WIDTH = 32,
    parameter int APB_ADDR_WIDTH = 12,
    parameter int REG_NUM        = 8,
    localparam int LOG2          = $clog2(REG_NUM)
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic                              psel,
    input  logic                              penable,
    input  logic                              pwrite,
    input  logic [APB_ADDR_WIDTH-1:0]         paddr,
    input  logic [APB_DATA_WIDTH-1:0]         pwdata,
    output logic [APB_DATA_WIDTH-1:0]         prdata,
    output logic                              pready,
    output logic                              pslverr,
    input  logic [REG_NUM*APB_DATA_WIDTH-1:0] reg_rdata_flat,
    output logic                              reg_apb_wen,
    output logic [APB_DATA_WIDTH-1:0]         reg_apb_wdata,
    output logic [LOG2-1:0]                   reg_apb_addr
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    state_t r_state;

    // ------------------------------------------------------------------
    // Unpacked view of the bank so a register can be selected by index.
    // ------------------------------------------------------------------
    logic [APB_DATA_WIDTH-1:0] w_regs [REG_NUM];

    generate
        for (genvar gi = 0; gi < REG_NUM; gi++) begin : g_unpack
            assign w_regs[gi] = reg_rdata_flat[gi*APB_DATA_WIDTH +: APB_DATA_WIDTH];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Setup-phase decode. The word index is taken from the byte address;
    // anything outside the word-aligned register window is an error.
    // The index range test only matters when REG_NUM is not a power of 2.
    // ------------------------------------------------------------------
    logic [LOG2-1:0]           w_index;
    logic                      w_misaligned;
    logic                      w_high_bits;
    logic                      w_over_range;
    logic                      w_err;
    logic                      w_setup;
    logic [APB_DATA_WIDTH-1:0] w_rd_word;

    assign w_index      = paddr[LOG2+1:2];
    assign w_misaligned = (paddr[1:0] != 2'b00);
    assign w_high_bits  = ((paddr >> (LOG2 + 2)) != '0);
    assign w_over_range = ({1'b0, w_index} >= (LOG2+1)'(REG_NUM));
    assign w_err        = w_misaligned | w_high_bits | w_over_range;
    assign w_setup      = psel & ~penable;
    assign w_rd_word    = w_over_range ? '0 : w_regs[w_index];

`ifdef APB_REG_WAIT_EN
    // Transfer attributes held across the wait cycle.
    logic                      r_write;
    logic                      r_err;
    logic [LOG2-1:0]           r_index;
    logic [APB_DATA_WIDTH-1:0] r_wdata;
    logic [APB_DATA_WIDTH-1:0] w_wait_rd_word;

    assign w_wait_rd_word = w_regs[r_index];
`endif

    // ------------------------------------------------------------------
    // Control FSM with registered outputs. The outputs for the completing
    // (access) cycle are loaded on the edge that leaves the previous
    // state, so they are valid throughout the access cycle itself.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= S_IDLE;
            prdata        <= '0;
            pready        <= 1'b0;
            pslverr       <= 1'b0;
            reg_apb_wen   <= 1'b0;
            reg_apb_wdata <= '0;
            reg_apb_addr  <= '0;
`ifdef APB_REG_WAIT_EN
            r_write       <= 1'b0;
            r_err         <= 1'b0;
            r_index       <= '0;
            r_wdata       <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    pready      <= 1'b0;
                    pslverr     <= 1'b0;
                    reg_apb_wen <= 1'b0;
                    prdata      <= '0;
                    // penable without a preceding setup is ignored here.
                    if (w_setup) begin
`ifdef APB_REG_WAIT_EN
                        r_write <= pwrite;
                        r_err   <= w_err;
                        r_index <= w_index;
                        r_wdata <= pwdata;
                        r_state <= S_WAIT;
`else
                        r_state <= S_ACCESS;
                        pready  <= 1'b1;
                        pslverr <= w_err;
                        if (!pwrite && !w_err) begin
                            prdata <= w_rd_word;
                        end
                        if (pwrite && !w_err) begin
                            reg_apb_wen   <= 1'b1;
                            reg_apb_addr  <= w_index;
                            reg_apb_wdata <= pwdata;
                        end
`endif
                    end
                end

`ifdef APB_REG_WAIT_EN
                S_WAIT: begin
                    if (!psel) begin
                        // Abort: nothing has been issued to the bank yet.
                        r_state       <= S_IDLE;
                        pready        <= 1'b0;
                        pslverr       <= 1'b0;
                        reg_apb_wen   <= 1'b0;
                        prdata        <= '0;
                        reg_apb_addr  <= '0;
                        reg_apb_wdata <= '0;
                    end else begin
                        r_state <= S_ACCESS;
                        pready  <= 1'b1;
                        pslverr <= r_err;
                        if (!r_write && !r_err) begin
                            prdata <= w_wait_rd_word;
                        end else begin
                            prdata <= '0;
                        end
                        if (r_write && !r_err) begin
                            reg_apb_wen   <= 1'b1;
                            reg_apb_addr  <= r_index;
                            reg_apb_wdata <= r_wdata;
                        end
                    end
                end
`endif

                S_ACCESS: begin
                    // Completing cycle; paddr/pwdata here are don't-care.
                    r_state     <= S_IDLE;
                    pready      <= 1'b0;
                    pslverr     <= 1'b0;
                    reg_apb_wen <= 1'b0;
                    prdata      <= '0;
                    if (!psel) begin
                        reg_apb_addr  <= '0;
                        reg_apb_wdata <= '0;
                    end
                end

                default: begin
                    r_state     <= S_IDLE;
                    pready      <= 1'b0;
                    pslverr     <= 1'b0;
                    reg_apb_wen <= 1'b0;
                    prdata      <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_reg_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apb_reg_slave
//  Purpose  : Self-checking bench for apb_reg_slave (default build, zero
//             wait states). A small register bank model is driven by the
//             DUT write strobe; expected responses come from a word-array
//             model updated per APB transfer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_apb_reg_slave;

    localparam int DW = 32;
    localparam int AW = 12;
    localparam int RN = 8;

    logic          clk;
    logic          resetn;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;
    logic [RN*DW-1:0] reg_rdata_flat;
    logic          reg_apb_wen;
    logic [DW-1:0] reg_apb_wdata;
    logic [2:0]    reg_apb_addr;

    int total;
    int bad;

    // Environment bank (fed by the DUT) and reference model (fed by the bench).
    logic [DW-1:0] bank [RN];
    logic [DW-1:0] mem  [RN];
    logic          load;

    apb_reg_slave #(
        .APB_DATA_WIDTH (DW),
        .APB_ADDR_WIDTH (AW),
        .REG_NUM        (RN)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .psel           (psel),
        .penable        (penable),
        .pwrite         (pwrite),
        .paddr          (paddr),
        .pwdata         (pwdata),
        .prdata         (prdata),
        .pready         (pready),
        .pslverr        (pslverr),
        .reg_rdata_flat (reg_rdata_flat),
        .reg_apb_wen    (reg_apb_wen),
        .reg_apb_wdata  (reg_apb_wdata),
        .reg_apb_addr   (reg_apb_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < RN; i++) bank[i] <= mem[i];
        end else if (reg_apb_wen) begin
            bank[reg_apb_addr] <= reg_apb_wdata;
        end
    end

    always_comb begin
        reg_rdata_flat = '0;
        for (int i = 0; i < RN; i++) reg_rdata_flat[i*DW +: DW] = bank[i];
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            psel    = 1'b0;
            penable = 1'b0;
        end
    endtask

    // One full APB transfer: setup cycle then access cycle.
    task automatic apb_xfer(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        logic          err;
        logic [2:0]    idx;
        logic [DW-1:0] exp_rd;
        idx    = addr[4:2];
        err    = (addr[1:0] != 2'b00) || (addr[AW-1:5] != '0);
        exp_rd = (!wr && !err) ? mem[idx] : '0;

        @(negedge clk);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = data;
        @(posedge clk);
        #1;
        check("acc_pready",  {31'b0, pready},      32'd1);
        check("acc_pslverr", {31'b0, pslverr},     {31'b0, err});
        check("acc_prdata",  prdata,               exp_rd);
        check("acc_wen",     {31'b0, reg_apb_wen}, {31'b0, wr && !err});
        if (wr && !err) begin
            check("acc_waddr", {29'b0, reg_apb_addr}, {29'b0, idx});
            check("acc_wdata", reg_apb_wdata,         data);
            mem[idx] = data;
        end

        @(negedge clk);
        penable = 1'b1;
        // Bus values during the access cycle must not matter.
        paddr   = AW'($urandom);
        pwdata  = $urandom;
        @(posedge clk);
        #1;
        check("end_pready",  {31'b0, pready},      32'd0);
        check("end_pslverr", {31'b0, pslverr},     32'd0);
        check("end_wen",     {31'b0, reg_apb_wen}, 32'd0);
        check("end_prdata",  prdata,               32'd0);
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        resetn  = 1'b0;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        load    = 1'b1;
        for (int i = 0; i < RN; i++) mem[i] = $urandom;
        mem[7] = 32'h1234_5678;

        repeat (3) @(posedge clk);
        #1;
        check("rst_pready",  {31'b0, pready},       32'd0);
        check("rst_pslverr", {31'b0, pslverr},      32'd0);
        check("rst_prdata",  prdata,                32'd0);
        check("rst_wen",     {31'b0, reg_apb_wen},  32'd0);
        check("rst_waddr",   {29'b0, reg_apb_addr}, 32'd0);
        check("rst_wdata",   reg_apb_wdata,         32'd0);
        @(negedge clk);
        load   = 1'b0;
        resetn = 1'b1;
        idle(1);

        // Directed cases.
        apb_xfer(1'b1, 12'h008, 32'hDEAD_BEEF);
        apb_xfer(1'b0, 12'h01C, 32'h0);
        apb_xfer(1'b1, 12'h020, 32'h1111_1111);
        apb_xfer(1'b1, 12'h006, 32'h2222_2222);
        apb_xfer(1'b0, 12'h006, 32'h0);
        apb_xfer(1'b1, 12'h004, 32'hA5A5_A5A5);
        apb_xfer(1'b0, 12'h004, 32'h0);
        apb_xfer(1'b0, 12'h008, 32'h0);

        // penable without setup in IDLE is ignored.
        @(negedge clk);
        psel    = 1'b1;
        penable = 1'b1;
        pwrite  = 1'b1;
        paddr   = 12'h000;
        pwdata  = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        check("noset_pready", {31'b0, pready},      32'd0);
        check("noset_wen",    {31'b0, reg_apb_wen}, 32'd0);
        idle(1);

        // Reset during the access cycle of a read.
        @(negedge clk);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 12'h01C;
        @(posedge clk);
        #1;
        check("prerst_pready", {31'b0, pready}, 32'd1);
        check("prerst_prdata", prdata,          mem[7]);
        penable = 1'b1;
        #2;
        resetn = 1'b0;
        #1;
        check("midrst_pready",  {31'b0, pready},      32'd0);
        check("midrst_prdata",  prdata,               32'd0);
        check("midrst_pslverr", {31'b0, pslverr},     32'd0);
        check("midrst_wen",     {31'b0, reg_apb_wen}, 32'd0);
        @(negedge clk);
        psel    = 1'b0;
        penable = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        apb_xfer(1'b0, 12'h01C, 32'h0);

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            int            sel;
            logic [AW-1:0] a;
            sel = int'($urandom_range(0, 9));
            if (sel <= 6) begin
                a = AW'($urandom_range(0, RN - 1)) << 2;
            end else if (sel == 7) begin
                a = (AW'($urandom_range(0, RN - 1)) << 2) | AW'($urandom_range(1, 3));
            end else if (sel == 8) begin
                a = AW'($urandom_range(8, 1023)) << 2;
            end else begin
                a = AW'($urandom);
            end
            apb_xfer(1'($urandom), a, $urandom);
            idle(int'($urandom_range(0, 2)));
        end

        idle(2);
        for (int i = 0; i < RN; i++) check("bank_final", bank[i], mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/apb_reg_slave.md
Name: apb_reg_slave

Overview:
- APB3 completer front-end for the peripheral register bank.
- Decodes PSEL/PENABLE/PWRITE/PADDR into the bank's single-cycle write strobe (reg_apb_wen/reg_apb_addr/reg_apb_wdata).
- Returns the bank's current register contents on PRDATA, with PREADY and PSLVERR generation.
- Sits between the APB interconnect and the register bank, which gives reg_apb_wen priority over other writers.

Parameters:
- APB_DATA_WIDTH, 32, data width of PWDATA/PRDATA and of each register.
- APB_ADDR_WIDTH, 12, width of PADDR (byte address within this slave's window).
- REG_NUM, 8, number of 32-bit word registers; index width LOG2 = $clog2(REG_NUM).

Ports:
- clk  input  1  single clock, all logic on posedge.
- resetn  input  1  asynchronous active-low reset.
- psel  input  1  APB select.
- penable  input  1  APB enable (access phase).
- pwrite  input  1  1 = write, 0 = read.
- paddr  input  APB_ADDR_WIDTH  byte address.
- pwdata  input  APB_DATA_WIDTH  write data.
- prdata  output  APB_DATA_WIDTH  read data, valid when pready=1 on a read.
- pready  output  1  transfer completes this cycle.
- pslverr  output  1  error response, valid when pready=1.
- reg_rdata_flat  input  REG_NUM*APB_DATA_WIDTH  register contents; register i at bits [i*W +: W].
- reg_apb_wen  output  1  one-cycle write strobe to the bank.
- reg_apb_wdata  output  APB_DATA_WIDTH  write data to the bank.
- reg_apb_addr  output  LOG2  register index to the bank.

Behaviour:
- Reset: asynchronous, active-low.
  - FSM goes to IDLE.
  - prdata, pready, pslverr, reg_apb_wen, reg_apb_wdata and reg_apb_addr all reset to 0.
  - Reset mid-transfer aborts it; no write strobe is issued.
- All outputs are registered.
- FSM states: IDLE, ACCESS (plus WAIT only with the optional feature).
- IDLE:
  - On psel=1 and penable=0 (setup phase), capture pwrite, index = paddr[LOG2+1:2] and pwdata, then go to ACCESS.
  - Set the registered outputs for the completing cycle at this same edge:
    - pready <= 1.
    - Error check: err = (paddr[1:0]!=0) or (paddr[APB_ADDR_WIDTH-1:LOG2+2]!=0) or (index>=REG_NUM).
    - pslverr <= err.
    - Read with no error: prdata <= register[index], sampled from reg_rdata_flat in the setup cycle. Otherwise prdata <= 0.
    - Write with no error: reg_apb_wen <= 1, reg_apb_addr <= index, reg_apb_wdata <= pwdata.
  - penable=1 while in IDLE (no preceding setup) is ignored: pready stays 0.
- ACCESS:
  - This is the completing cycle (master drives psel=1, penable=1).
  - Next edge: pready, pslverr, reg_apb_wen and prdata return to 0; state returns to IDLE.
  - The bank captures the write at the end of ACCESS, so a write is visible in reg_rdata_flat 2 cycles after setup.
- Latency: zero wait states; each transfer takes 2 cycles (setup + access).
- Back-to-back: a new setup immediately after ACCESS is accepted; throughput is 1 transfer per 2 cycles.
- Read-after-write back-to-back: the read setup samples reg_rdata_flat after the write landed, so the new value is returned.
- Abort: psel=0 while in ACCESS/WAIT → return to IDLE and clear all outputs.
  - In WAIT, no strobe is issued.
  - In ACCESS without the feature, the strobe has already fired; this case is not recoverable and is not a protocol-legal case.
- Error transfers: no write strobe; prdata = 0; pslverr = 1 only while pready = 1.
- paddr/pwdata changes during ACCESS are ignored (values captured at setup).

Optional Feature:
- Macro: APB_REG_WAIT_EN.
- Defined:
  - Setup moves to WAIT (pready=0, outputs 0).
  - WAIT always moves to ACCESS on the next edge.
  - At the WAIT→ACCESS edge, pready, pslverr and reg_apb_wen assert, and prdata is re-sampled from reg_rdata_flat in the WAIT cycle.
  - Transfer = 3 cycles; a psel drop in WAIT aborts with no strobe.
- Undefined: no WAIT state; zero-wait-state timing as above.

Test Plan:
- Write paddr=0x008, pwdata=0xDEADBEEF → reg_apb_wen=1 for exactly one cycle with pready=1, reg_apb_addr=2, reg_apb_wdata=0xDEADBEEF, pslverr=0.
- Read paddr=0x01C with register 7=0x12345678 → prdata=0x12345678, pready=1, pslverr=0 in the access cycle; prdata=0 on the next cycle.
- Write paddr=0x020 (index 8), then paddr=0x006 (misaligned) → pslverr=1 with pready=1, reg_apb_wen never asserted.
- Back-to-back write 0xA5A5A5A5 to 0x004, then read 0x004, with a bank model → read returns 0xA5A5A5A5; total 4 cycles.
- resetn low during the access cycle of a read → pready/prdata/pslverr/reg_apb_wen=0 immediately; the next setup after release completes normally.
- With APB_REG_WAIT_EN, write 0x00C → pready=0 in the first access cycle, =1 in the second; reg_apb_wen coincides with pready.
